// File: rtl/paddle_move_sequencer.sv
// Frame-paced paddle move controller: per frame picks human or AI direction and emits a burst of move pulses.
// Optional macro PADDLE_ACCEL_EN doubles the burst length after a direction is held for ACCEL_FRAMES frames.
module paddle_move_sequencer #(
    parameter int unsigned STEPS_PER_FRAME = 2,
    parameter int unsigned IDLE_FRAMES     = 120,
    parameter int unsigned ACCEL_FRAMES    = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [3:0] button_n,
    input  logic       ai_valid,
    input  logic [3:0] ai_dir,
    output logic       ai_ready,
    output logic [3:0] move_button,
    output logic       owner,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned STEP_W = 5;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0]  IDLE_MAX   = CNT_W'(IDLE_FRAMES);
    localparam logic [STEP_W-1:0] STEPS_BASE = STEP_W'(STEPS_PER_FRAME);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_BURST  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        btn_meta_q, btn_s_q;
    logic              gap_q, gap_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic [3:0]        dir_q, dir_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic              owner_q, owner_d;
    logic              ai_ready_q, ai_ready_d;
    logic [3:0]        move_button_q, move_button_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [3:0]        dir_sel;
    logic [STEP_W-1:0] steps_sel;

`ifdef PADDLE_ACCEL_EN
    localparam logic [CNT_W-1:0] ACCEL_MIN = CNT_W'(ACCEL_FRAMES);
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`else
    logic unused_accel;
    assign unused_accel = ^CNT_W'(ACCEL_FRAMES);
`endif

    // Idle-frame count after a SAMPLE that sees button vector b.
    function automatic logic [CNT_W-1:0] idle_next(input logic [3:0] b, input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (b != 4'hF)
            r = '0;
        else if (c >= IDLE_MAX)
            r = IDLE_MAX;
        else
            r = c + CNT_W'(1);
        return r;
    endfunction

    function automatic logic ai_owns(input logic [3:0] b, input logic [CNT_W-1:0] c);
        return (b == 4'hF) && (idle_next(b, c) == IDLE_MAX);
    endfunction

    // Two-flop button synchronizer; released state is all ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta_q <= 4'hF;
            btn_s_q    <= 4'hF;
        end else begin
            btn_meta_q <= button_n;
            btn_s_q    <= btn_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            gap_q         <= 1'b0;
            steps_left_q  <= '0;
            dir_q         <= 4'h0;
            idle_cnt_q    <= '0;
            owner_q       <= 1'b0;
            ai_ready_q    <= 1'b0;
            move_button_q <= 4'hF;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            steps_left_q  <= steps_left_d;
            dir_q         <= dir_d;
            idle_cnt_q    <= idle_cnt_d;
            owner_q       <= owner_d;
            ai_ready_q    <= ai_ready_d;
            move_button_q <= move_button_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef PADDLE_ACCEL_EN
    always_ff @(posedge clock) begin
        if (reset)
            hold_cnt_q <= '0;
        else
            hold_cnt_q <= hold_cnt_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        idle_cnt_d   = idle_cnt_q;
        owner_d      = owner_q;
        ai_ready_d   = 1'b0;
        overrun_d    = overrun_q;
        dir_sel      = 4'h0;
        steps_sel    = STEPS_BASE;
`ifdef PADDLE_ACCEL_EN
        hold_cnt_d   = hold_cnt_q;
`endif

        if (frame_tick && (state_q != ST_IDLE))
            overrun_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // btn_meta_q now is what btn_s_q will be in SAMPLE, so the strobe can be registered.
                if (frame_tick) begin
                    state_d    = ST_SAMPLE;
                    ai_ready_d = ai_owns(btn_meta_q, idle_cnt_q);
                end
            end
            ST_SAMPLE: begin
                idle_cnt_d = idle_next(btn_s_q, idle_cnt_q);
                owner_d    = ai_owns(btn_s_q, idle_cnt_q);
                if (owner_d)
                    dir_sel = ai_valid ? ai_dir : 4'h0;
                else
                    dir_sel = ~btn_s_q;
                if (dir_sel[0] && dir_sel[1])
                    dir_sel[1:0] = 2'b00;
                if (dir_sel[2] && dir_sel[3])
                    dir_sel[3:2] = 2'b00;
`ifdef PADDLE_ACCEL_EN
                if ((dir_sel != 4'h0) && (dir_sel == dir_q))
                    hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
                else
                    hold_cnt_d = '0;
                if (hold_cnt_d >= ACCEL_MIN)
                    steps_sel = STEP_W'(2 * STEPS_PER_FRAME);
`endif
                dir_d        = dir_sel;
                steps_left_d = steps_sel;
                gap_d        = 1'b0;
                state_d      = ST_BURST;
            end
            ST_BURST: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (steps_left_q <= STEP_W'(1)) begin
                    gap_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d        = 1'b0;
                    steps_left_d = steps_left_q - STEP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d        = (state_d != ST_IDLE);
        move_button_d = ((state_d == ST_BURST) && !gap_d) ? ~dir_d : 4'hF;
    end

    assign ai_ready    = ai_ready_q;
    assign move_button = move_button_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_paddle_move_sequencer.sv
// Bench for paddle_move_sequencer: two instances (long and short idle timeout) against a per-frame reference model.
module tb_paddle_move_sequencer;

    localparam int unsigned SPF     = 2;
    localparam int unsigned IDLE_A  = 120;
    localparam int unsigned IDLE_B  = 3;
    localparam int unsigned ACCEL_A = 30;
    localparam int unsigned ACCEL_B = 2;

    logic       clock;
    logic       reset;
    logic       frame_tick;
    logic [3:0] button_n;
    logic       ai_valid;
    logic [3:0] ai_dir;
    logic       ai_ready [2];
    logic [3:0] mb       [2];
    logic       owner    [2];
    logic       busy     [2];
    logic       overrun  [2];

    paddle_move_sequencer #(.STEPS_PER_FRAME(SPF), .IDLE_FRAMES(IDLE_A), .ACCEL_FRAMES(ACCEL_A)) dut_a (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .button_n(button_n),
        .ai_valid(ai_valid), .ai_dir(ai_dir), .ai_ready(ai_ready[0]), .move_button(mb[0]),
        .owner(owner[0]), .busy(busy[0]), .overrun(overrun[0]));

    paddle_move_sequencer #(.STEPS_PER_FRAME(SPF), .IDLE_FRAMES(IDLE_B), .ACCEL_FRAMES(ACCEL_B)) dut_b (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .button_n(button_n),
        .ai_valid(ai_valid), .ai_dir(ai_dir), .ai_ready(ai_ready[1]), .move_button(mb[1]),
        .owner(owner[1]), .busy(busy[1]), .overrun(overrun[1]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int total;
    int bad;

    // Frame-level reference model state, one slot per instance.
    int         m_idle  [2];
    logic       m_owner [2];
    logic [3:0] m_prev  [2];
    int         m_hold  [2];
    logic       m_ovr   [2];
    int         idle_lim  [2];
    int         accel_lim [2];

    typedef struct {
        logic [3:0] btn;
        logic       av;
        logic [3:0] ad;
        int         xtick;
        logic [3:0] exp_mb;
    } vec_t;
    vec_t tab [8];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_idle[d]  = 0;
            m_owner[d] = 1'b0;
            m_prev[d]  = 4'h0;
            m_hold[d]  = 0;
            m_ovr[d]   = 1'b0;
        end
    endtask

    // What one frame does: new owner, masked direction and number of pulses.
    task automatic predict(input int d, input logic [3:0] btn, input logic av, input logic [3:0] ad,
                           output logic nown, output logic [3:0] dir, output int steps);
        if (btn != 4'hF) begin
            m_idle[d] = 0;
            nown = 1'b0;
        end else begin
            if (m_idle[d] < idle_lim[d]) m_idle[d]++;
            nown = (m_idle[d] == idle_lim[d]);
        end
        dir = nown ? (av ? ad : 4'h0) : ~btn;
        if (dir[0] && dir[1]) dir[1:0] = 2'b00;
        if (dir[2] && dir[3]) dir[3:2] = 2'b00;
        steps = SPF;
`ifdef PADDLE_ACCEL_EN
        if (dir != 4'h0 && dir == m_prev[d]) m_hold[d] = (m_hold[d] < 255) ? m_hold[d] + 1 : 255;
        else m_hold[d] = 0;
        if (m_hold[d] >= accel_lim[d]) steps = 2 * SPF;
`endif
        m_prev[d] = dir;
    endtask

    task automatic run_frame(input logic [3:0] btn, input logic av, input logic [3:0] ad, input int xtick,
                             input logic tab_en, input logic [3:0] tab_mb, input string tag);
        logic       nown [2];
        logic       oown [2];
        logic [3:0] ndir [2];
        int         ns   [2];
        int         mins, maxs, xt, last;
        logic [3:0] emb;
        @(posedge clock); #1;
        button_n = btn; ai_valid = av; ai_dir = ad;
        repeat (3) @(posedge clock);
        #1 frame_tick = 1'b1;
        for (int d = 0; d < 2; d++) begin
            oown[d] = m_owner[d];
            predict(d, btn, av, ad, nown[d], ndir[d], ns[d]);
            m_owner[d] = nown[d];
        end
        mins = (ns[0] < ns[1]) ? ns[0] : ns[1];
        maxs = (ns[0] > ns[1]) ? ns[0] : ns[1];
        xt = (xtick >= 1 && xtick <= 1 + 2 * mins) ? xtick : 0;
        @(posedge clock); #1 frame_tick = 1'b0;
        for (int c = 1; c <= 2 + 2 * maxs; c++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                last = 1 + 2 * ns[d];
                emb = (c >= 2 && c <= last && (c % 2) == 0) ? ~ndir[d] : 4'hF;
                chk($sformatf("%s.d%0d.c%0d.mb", tag, d, c), 8'(mb[d]), 8'(emb));
                chk($sformatf("%s.d%0d.c%0d.busy", tag, d, c), 8'(busy[d]), 8'(c <= last));
                chk($sformatf("%s.d%0d.c%0d.ai_ready", tag, d, c), 8'(ai_ready[d]), 8'((c == 1) && nown[d]));
                chk($sformatf("%s.d%0d.c%0d.owner", tag, d, c), 8'(owner[d]), 8'((c == 1) ? oown[d] : nown[d]));
                chk($sformatf("%s.d%0d.c%0d.overrun", tag, d, c), 8'(overrun[d]),
                    8'(m_ovr[d] || (xt != 0 && c > xt)));
            end
            if (tab_en && c >= 2 && c <= 1 + 2 * ns[0] && (c % 2) == 0)
                chk($sformatf("%s.tab.c%0d", tag, c), 8'(mb[0]), 8'(tab_mb));
            frame_tick = (c == xt);
        end
        frame_tick = 1'b0;
        if (xt != 0)
            for (int d = 0; d < 2; d++) m_ovr[d] = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock); #1;
        reset = 1'b1; frame_tick = 1'b0;
        @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.d%0d.mb", tag, d), 8'(mb[d]), 8'hF);
            chk($sformatf("%s.d%0d.owner", tag, d), 8'(owner[d]), 8'h0);
            chk($sformatf("%s.d%0d.ai_ready", tag, d), 8'(ai_ready[d]), 8'h0);
            chk($sformatf("%s.d%0d.busy", tag, d), 8'(busy[d]), 8'h0);
            chk($sformatf("%s.d%0d.overrun", tag, d), 8'(overrun[d]), 8'h0);
        end
        @(posedge clock); #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        total = 0; bad = 0;
        idle_lim[0] = IDLE_A;   idle_lim[1] = IDLE_B;
        accel_lim[0] = ACCEL_A; accel_lim[1] = ACCEL_B;
        reset = 1'b0; frame_tick = 1'b0; button_n = 4'hF; ai_valid = 1'b0; ai_dir = 4'h0;
        model_reset();

        tab[0] = '{4'hF, 1'b0, 4'h0, 0, 4'hF};
        tab[1] = '{4'hE, 1'b1, 4'h8, 3, 4'hE};
        tab[2] = '{4'hC, 1'b0, 4'h0, 0, 4'hF};
        tab[3] = '{4'h3, 1'b0, 4'h0, 0, 4'hF};
        tab[4] = '{4'h7, 1'b0, 4'h0, 0, 4'h7};
        tab[5] = '{4'hA, 1'b0, 4'h0, 5, 4'hA};
        tab[6] = '{4'h0, 1'b1, 4'h4, 0, 4'hF};
        tab[7] = '{4'hD, 1'b0, 4'h0, 0, 4'hD};

        do_reset("rst0");
        for (int i = 0; i < 8; i++)
            run_frame(tab[i].btn, tab[i].av, tab[i].ad, tab[i].xtick, 1'b1, tab[i].exp_mb, $sformatf("tab%0d", i));

        // Idle timeout hands the short-timeout instance to the AI, a press takes it back.
        do_reset("rst1");
        for (int f = 0; f < 3; f++)
            run_frame(4'hF, 1'b1, 4'h8, 0, 1'b0, 4'hF, $sformatf("idle%0d", f));
        @(negedge clock);
        chk("ai_owner_after3", 8'(owner[1]), 8'h1);
        chk("human_owner_after3", 8'(owner[0]), 8'h0);
        run_frame(4'hF, 1'b1, 4'h8, 0, 1'b0, 4'hF, "ai4");
        run_frame(4'hF, 1'b1, 4'h3, 0, 1'b0, 4'hF, "ai_conflict");
        run_frame(4'hF, 1'b0, 4'h2, 0, 1'b0, 4'hF, "ai_novalid");
        run_frame(4'hB, 1'b1, 4'h8, 0, 1'b0, 4'hB, "back_human");
        @(negedge clock);
        chk("owner_back_human", 8'(owner[1]), 8'h0);
        run_frame(4'h7, 1'b0, 4'h0, 0, 1'b0, 4'h7, "hold_r1");
        run_frame(4'h7, 1'b0, 4'h0, 0, 1'b0, 4'h7, "hold_r2");
        run_frame(4'h7, 1'b0, 4'h0, 0, 1'b0, 4'h7, "hold_r3");
        run_frame(4'hF, 1'b0, 4'h0, 0, 1'b0, 4'hF, "release");
        run_frame(4'h7, 1'b0, 4'h0, 0, 1'b0, 4'h7, "hold_again");

        // Reset in the middle of a burst kills the remaining pulses.
        @(posedge clock); #1 button_n = 4'hE;
        repeat (3) @(posedge clock);
        #1 frame_tick = 1'b1;
        @(posedge clock); #1 frame_tick = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("midrst.pulse", 8'(mb[0]), 8'hE);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst.mb", 8'(mb[0]), 8'hF);
        chk("midrst.busy", 8'(busy[0]), 8'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk($sformatf("midrst.after%0d.mb", c), 8'(mb[0]), 8'hF);
            chk($sformatf("midrst.after%0d.busy", c), 8'(busy[1]), 8'h0);
        end
        model_reset();

        for (int f = 0; f < 40; f++) begin
            logic [3:0] b;
            logic [3:0] a;
            int         x;
            b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            a = 4'($urandom);
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 1 + 2 * SPF)) : 0;
            run_frame(b, 1'($urandom), a, x, 1'b0, 4'hF, $sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paddle_move_sequencer.md
# paddle_move_sequencer

Frame-paced move controller that sits in front of the paddle mover and drives its active-low `button[3:0]` input. Once per video frame it picks the move source: the human push-buttons, or an AI requester after a human-idle timeout. It then issues a bounded burst of one-cycle move pulses, so paddle speed depends on frame rate and not on the system clock.

## Interface
Parameters:
- `STEPS_PER_FRAME`, default 2: move pulses per frame per axis. Legal range 1..15.
- `IDLE_FRAMES`, default 120: consecutive human-idle frames before the AI takes over. Legal range 0..255.
- `ACCEL_FRAMES`, default 30: consecutive frames holding the same direction before acceleration. Legal range 1..255. Used only with `PADDLE_ACCEL_EN`.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `button_n` in 4: raw human buttons, active-low. Bit 0 down, 1 up, 2 left, 3 right.
- `ai_valid` in 1: AI direction request valid.
- `ai_dir` in 4: AI direction, active-high, same bit order as `button_n`.
- `ai_ready` out 1: one-cycle accept strobe for the AI request.
- `move_button` out 4: active-low move vector to the paddle mover.
- `owner` out 1: 0 = human, 1 = AI.
- `busy` out 1: high while a frame burst is in progress.
- `overrun` out 1: sticky flag; a `frame_tick` arrived while busy.

## Operation
- `button_n` passes through a 2-flop synchronizer. All decisions use the synchronized value `btn_s`.
- FSM has three states: IDLE, SAMPLE, BURST. BURST alternates PULSE and GAP cycles.
  - IDLE: on `frame_tick`, go to SAMPLE.
  - SAMPLE (1 cycle): update the owner, latch the direction vector `dir[3:0]` (active-high), compute `steps`, then go to BURST.
  - BURST: PULSE drives `move_button = ~dir` for 1 cycle. GAP drives 4'b1111 for 1 cycle. Repeat `steps` times, then go to IDLE.
- Owner update in SAMPLE:
  - Any `btn_s` bit low: idle counter cleared, owner = human.
  - Otherwise: idle counter increments, saturating at `IDLE_FRAMES`. Owner = AI once the count equals `IDLE_FRAMES`; with `IDLE_FRAMES=0` the switch to AI is immediate.
- Direction source:
  - Human owner: `dir = ~btn_s`.
  - AI owner: `ai_ready` is high during SAMPLE. If `ai_valid` is high in the same cycle, `dir = ai_dir`, otherwise `dir = 0`.
  - `ai_ready` is never asserted when owner = human.
- Conflict masking after source selection:
  - Bits 0 and 1 both set: both cleared.
  - Bits 2 and 3 both set: both cleared.
- `dir == 0`: BURST still runs `steps` pulse/gap pairs, with `move_button` held at 4'b1111 throughout.
- `frame_tick` outside IDLE is ignored and sets `overrun`. Only reset clears `overrun`.
- Step count width: 5 bits, maximum 30.

## Timing
- Reset values:
  - `move_button` = 4'b1111
  - `owner` = 0
  - `ai_ready` = 0
  - `busy` = 0
  - `overrun` = 0
  - FSM in IDLE; idle and hold counters = 0
- `frame_tick` at cycle T, with the FSM in IDLE:
  - SAMPLE at T+1; `ai_ready` is high at T+1 only.
  - Step k (k = 0..steps-1) drives `move_button` low at T+2+2k and back to 1111 at T+3+2k.
  - `busy` is high from T+1 through T+1+2·steps inclusive. The FSM is in IDLE at T+2+2·steps.
- Human button to effect: a change in `button_n` is visible in `btn_s` 2 cycles later. It affects only the next SAMPLE.
- `owner` updates at the end of SAMPLE and is visible from T+2.
- Reset mid-burst: `move_button` is 1111 on the next cycle and no further pulses are issued.
- `frame_tick` exactly on the last GAP cycle counts as overrun; that frame is dropped.

## Configuration
- `PADDLE_ACCEL_EN` defined:
  - A hold counter, 8-bit saturating, increments in SAMPLE when `dir` is nonzero and equals the previous frame's `dir`.
  - The hold counter clears in SAMPLE on any change of `dir` or on `dir == 0`.
  - When the hold counter ≥ `ACCEL_FRAMES`, `steps = 2·STEPS_PER_FRAME`.
- `PADDLE_ACCEL_EN` undefined: `steps = STEPS_PER_FRAME` always; no hold counter is instantiated.

## Test plan
- Reset, then `frame_tick` with all buttons released and `IDLE_FRAMES=120` → `move_button` stays 1111; `owner` = 0; `busy` is high for 5 cycles.
- `button_n` = 4'b1110 held ≥3 cycles, then `frame_tick` at T → `move_button` = 4'b1110 at T+2 and T+4, 1111 at T+3 and T+5; idle at T+6.
- `button_n` = 4'b1100 (up and down together) → `move_button` stays 1111 for the whole burst.
- `IDLE_FRAMES=3`, no buttons pressed:
  - After 3 frames, `owner` = 1.
  - 4th frame with `ai_valid=1`, `ai_dir=4'b1000` → `ai_ready` pulses at T+1; `move_button` = 4'b0111 twice.
  - Pressing any button returns `owner` to 0 at the next frame.
- `frame_tick` at T and again at T+3 → `overrun` = 1 from T+4 and remains set until reset; burst count unchanged.
- With `PADDLE_ACCEL_EN` and `ACCEL_FRAMES=2`, hold right for 3 frames → frames 1 and 2 issue 2 pulses; frame 3 issues 4 pulses. Releasing the button clears the hold counter.
